// File: rtl/reg_bank.sv
// reg_bank: 16-entry register file with one write port and two registered read ports.
// The write port can write the whole word, either half, or swap the two halves in place.
// Each read port loads a register value or a fixed constant into its output register.
module reg_bank #(
  parameter int unsigned         DATA_W = 64,
  parameter logic [DATA_W-1:0]   CNST_A = '0,
  parameter logic [DATA_W-1:0]   CNST_B = {{(DATA_W-1){1'b0}}, 1'b1}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              regwen,
  input  logic [DATA_W-1:0] inA,
  input  logic [3:0]        selwreg,
  input  logic [1:0]        endreg,
  input  logic [3:0]        seloutA,
  input  logic [3:0]        seloutB,
  input  logic              cnstA,
  input  logic              cnstB,
  input  logic              enrregA,
  input  logic              enrregB,
  output logic [DATA_W-1:0] outA,
  output logic [DATA_W-1:0] outB
);

  localparam int unsigned HalfW = DATA_W / 2;
  localparam int unsigned NumRegs = 16;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [DATA_W-1:0] wr_old;

  assign wr_old = regs_q[selwreg];

  // Write-port next state: an endreg bit of 0 lets its half through; 11 swaps halves.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (regwen) begin
      unique case (endreg)
        2'b00: regs_d[selwreg] = inA;
        2'b01: regs_d[selwreg] = {inA[DATA_W-1:HalfW], wr_old[HalfW-1:0]};
        2'b10: regs_d[selwreg] = {wr_old[DATA_W-1:HalfW], inA[HalfW-1:0]};
        2'b11: regs_d[selwreg] = {wr_old[HalfW-1:0], wr_old[DATA_W-1:HalfW]};
        default: regs_d[selwreg] = wr_old;
      endcase
    end
  end

  // Read-port next state: reads use the pre-write array, so a same-edge write is not bypassed.
  always_comb begin
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    if (enrregA) begin
      out_a_d = cnstA ? CNST_A : regs_q[seloutA];
    end
    if (enrregB) begin
      out_b_d = cnstB ? CNST_B : regs_q[seloutB];
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign outA = out_a_q;
  assign outB = out_b_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed and random stimulus for reg_bank checked against a behavioural model.
module tb_reg_bank;

  localparam logic [63:0] CA = 64'h0;
  localparam logic [63:0] CB = 64'h1;
  localparam logic [63:0] LoMask = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] HiMask = 64'hFFFF_FFFF_0000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        regwen;
  logic [63:0] inA;
  logic [3:0]  selwreg;
  logic [1:0]  endreg;
  logic [3:0]  seloutA;
  logic [3:0]  seloutB;
  logic        cnstA;
  logic        cnstB;
  logic        enrregA;
  logic        enrregB;
  logic [63:0] outA;
  logic [63:0] outB;

  int nvec = 0;
  int nerr = 0;

  // Reference model state.
  logic [63:0] mem [16];
  logic [63:0] ma;
  logic [63:0] mb;

  always #5 clock = ~clock;

  reg_bank #(
    .DATA_W(64),
    .CNST_A(CA),
    .CNST_B(CB)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .regwen (regwen),
    .inA    (inA),
    .selwreg(selwreg),
    .endreg (endreg),
    .seloutA(seloutA),
    .seloutB(seloutB),
    .cnstA  (cnstA),
    .cnstB  (cnstB),
    .enrregA(enrregA),
    .enrregB(enrregB),
    .outA   (outA),
    .outB   (outB)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    regwen = 0; inA = '0; selwreg = 0; endreg = 0;
    seloutA = 0; seloutB = 0; cnstA = 0; cnstB = 0; enrregA = 0; enrregB = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    ma = '0;
    mb = '0;
  endtask

  // Advance one clock, apply the register-file rules to the model, then compare both ports.
  task automatic cycle();
    logic [63:0] cur;
    logic [63:0] hi;
    logic [63:0] lo;
    @(posedge clock);
    #1;
    if (enrregA) ma = cnstA ? CA : mem[seloutA];
    if (enrregB) mb = cnstB ? CB : mem[seloutB];
    if (regwen) begin
      cur = mem[selwreg];
      hi  = cur >> 32;
      lo  = cur & LoMask;
      case (endreg)
        2'd0: mem[selwreg] = inA;
        2'd1: mem[selwreg] = (inA & HiMask) | lo;
        2'd2: mem[selwreg] = (hi << 32) | (inA & LoMask);
        default: mem[selwreg] = (lo << 32) | hi;
      endcase
    end
    chk("outA", outA, ma);
    chk("outB", outB, mb);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [1:0] mode, input logic [63:0] d);
    idle();
    regwen = 1; selwreg = idx; endreg = mode; inA = d;
    cycle();
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    idle();
    enrregA = 1; seloutA = a; enrregB = 1; seloutB = b;
    cycle();
  endtask

  initial begin
    idle();
    model_reset();
    reset_n = 0;
    #23;
    reset_n = 1;
    @(negedge clock);
    chk("rst_outA", outA, 64'h0);
    chk("rst_outB", outB, 64'h0);

    // Full write and read.
    wr(4'hA, 2'b00, 64'd24);
    rd(4'hA, 4'hB);
    chk("full_a", outA, 64'd24);
    chk("full_b", outB, 64'd0);

    // Half writes.
    wr(4'd3, 2'b00, 64'h1111_2222_3333_4444);
    wr(4'd3, 2'b01, 64'hAAAA_BBBB_CCCC_DDDD);
    rd(4'd3, 4'd3);
    chk("half_hi", outA, 64'hAAAA_BBBB_3333_4444);
    wr(4'd3, 2'b10, 64'h0);
    rd(4'd3, 4'd0);
    chk("half_lo", outA, 64'hAAAA_BBBB_0000_0000);

    // Swap ignores inA.
    wr(4'd5, 2'b00, 64'h0123_4567_89AB_CDEF);
    wr(4'd5, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(4'd0, 4'd5);
    chk("swap", outB, 64'h89AB_CDEF_0123_4567);

    // regwen=0 leaves the register alone.
    idle();
    selwreg = 4'd5; inA = 64'hDEAD; endreg = 2'b00;
    cycle();
    rd(4'd5, 4'd5);
    chk("no_wen", outA, 64'h89AB_CDEF_0123_4567);

    // Constants override the selection, then outputs hold with enables low.
    idle();
    enrregA = 1; enrregB = 1; cnstA = 1; cnstB = 1; seloutA = 4'd3; seloutB = 4'd5;
    cycle();
    chk("cnst_a", outA, CA);
    chk("cnst_b", outB, CB);
    idle();
    seloutA = 4'd5; seloutB = 4'd3; cnstA = 0; cnstB = 0;
    cycle();
    cycle();
    chk("hold_a", outA, CA);
    chk("hold_b", outB, CB);

    // Collision: same-edge read sees the old value, next read sees the new one.
    wr(4'd7, 2'b00, 64'hDEAD_BEEF);
    idle();
    regwen = 1; selwreg = 4'd7; inA = 64'h55; enrregA = 1; seloutA = 4'd7;
    cycle();
    chk("coll_old", outA, 64'hDEAD_BEEF);
    rd(4'd7, 4'd7);
    chk("coll_new", outA, 64'h55);

    // Asynchronous reset pulse mid-clock.
    @(posedge clock);
    #3;
    reset_n = 0;
    #1;
    model_reset();
    chk("arst_a", outA, 64'h0);
    chk("arst_b", outB, 64'h0);
    #199;
    idle();
    reset_n = 1;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i));
      chk("post_rst_a", outA, 64'h0);
    end

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      regwen  = ($urandom_range(0, 3) != 0);
      inA     = {$urandom, $urandom};
      selwreg = 4'($urandom_range(0, 15));
      endreg  = 2'($urandom_range(0, 3));
      seloutA = 4'($urandom_range(0, 15));
      seloutB = 4'($urandom_range(0, 15));
      cnstA   = ($urandom_range(0, 7) == 0);
      cnstB   = ($urandom_range(0, 7) == 0);
      enrregA = ($urandom_range(0, 3) != 0);
      enrregB = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
